song_sequencer: RTL and testbench

Playback controller for the rhythm-game datapath. It selects a song on the song loader, captures the loader's three 100-step note patterns (red, blue, yellow) and the total note count, then plays the patterns out one step per beat. Each beat emits a one-cycle strobe with the three note bits, which feed the note-scroll and hit-judge logic. It supports start, pause and abort, and reports progress and completion.

---
 rtl/song_sequencer_pkg.sv | 24 ++
 rtl/song_sequencer_beat_timer.sv | 30 +++
 rtl/song_sequencer.sv | 119 +++++++++++
 tb/tb_song_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// rtl/song_sequencer_pkg.sv - shared constants, state encoding and helpers for the song sequencer
package song_sequencer_pkg;

  localparam int PATTERN_LEN_DEFAULT = 100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] SONG_NONE             = 5'b00000;
  localparam logic [4:0] SONG_TAKE_ON_ME       = 5'b00011;
  localparam logic [4:0] SONG_THROUGH_THE_FIRE = 5'b11111;
  localparam logic [4:0] SONG_VLAD_BIT         = 5'b01010;
  localparam logic [4:0] SONG_BRIAN_FULL_MARKS = 5'b10111;

  function automatic logic [1:0] popcount3(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/song_sequencer_beat_timer.sv
// rtl/song_sequencer_beat_timer.sv - modulo-BEAT_CYCLES counter with clear/hold and a terminal tick
module beat_timer #(
  parameter int BEAT_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);

  logic [CW-1:0] count;

  // hold suppresses the tick so a pause landing on terminal count keeps the count parked there
  assign tick = !clear && !hold && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - loads a song's note patterns and plays them out one step per beat
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int PATTERN_LEN = PATTERN_LEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic [4:0]             song_select,
  output logic [4:0]             loader_select,
  input  logic [PATTERN_LEN-1:0] loader_red,
  input  logic [PATTERN_LEN-1:0] loader_blue,
  input  logic [PATTERN_LEN-1:0] loader_yellow,
  input  logic [7:0]             loader_total_notes,
  output logic                   beat_strobe,
  output logic                   note_red,
  output logic                   note_blue,
  output logic                   note_yellow,
  output logic [6:0]             beat_index,
  output logic [7:0]             total_notes,
  output logic [7:0]             notes_emitted,
  output logic                   busy,
  output logic                   done
);

  state_t                 state, next_state;
  logic [PATTERN_LEN-1:0] red_sr, blue_sr, yellow_sr;
  logic [6:0]             step_count;
  logic                   tick, active, start_go, last_step;
  logic                   timer_clear, timer_hold;
  logic [8:0]             emitted_sum;

  assign active      = (state == S_LOAD) || (state == S_PLAY) || (state == S_PAUSE);
  assign busy        = active;
  assign done        = (state == S_DONE);
  assign start_go    = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign last_step   = beat_strobe && (beat_index == 7'(PATTERN_LEN - 1));
  assign timer_clear = abort || start_go;
  // the timer runs from LOAD so the registered strobe lands BEAT_CYCLES after acceptance
  assign timer_hold  = pause || !active;
  assign emitted_sum = {1'b0, notes_emitted} +
                       {7'b0, popcount3(red_sr[PATTERN_LEN-1], blue_sr[PATTERN_LEN-1],
                                        yellow_sr[PATTERN_LEN-1])};

  beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) u_beat_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .hold  (timer_hold),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start) next_state = S_LOAD;
        S_LOAD:  next_state = S_PLAY;
        S_PLAY:  if (last_step) next_state = S_DONE;
                 else if (pause) next_state = S_PAUSE;
        S_PAUSE: if (!pause) next_state = S_PLAY;
        S_DONE:  if (start) next_state = S_LOAD;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || abort) begin
      loader_select <= '0;
      red_sr        <= '0;
      blue_sr       <= '0;
      yellow_sr     <= '0;
      step_count    <= '0;
      beat_strobe   <= 1'b0;
      note_red      <= 1'b0;
      note_blue     <= 1'b0;
      note_yellow   <= 1'b0;
      beat_index    <= '0;
      total_notes   <= '0;
      notes_emitted <= '0;
    end else begin
      beat_strobe <= tick;
      note_red    <= tick & red_sr[PATTERN_LEN-1];
      note_blue   <= tick & blue_sr[PATTERN_LEN-1];
      note_yellow <= tick & yellow_sr[PATTERN_LEN-1];
      if (start_go) begin
        loader_select <= song_select;
        notes_emitted <= '0;
        beat_index    <= '0;
        step_count    <= '0;
      end else if (state == S_LOAD) begin
        red_sr      <= loader_red;
        blue_sr     <= loader_blue;
        yellow_sr   <= loader_yellow;
        total_notes <= loader_total_notes;
      end else if (tick) begin
        red_sr        <= {red_sr[PATTERN_LEN-2:0], 1'b0};
        blue_sr       <= {blue_sr[PATTERN_LEN-2:0], 1'b0};
        yellow_sr     <= {yellow_sr[PATTERN_LEN-2:0], 1'b0};
        beat_index    <= step_count;
        step_count    <= step_count + 7'd1;
        notes_emitted <= emitted_sum[8] ? 8'hFF : emitted_sum[7:0];
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer with a small song loader model
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  localparam int BC = 4;
  localparam int PL = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [4:0]    song_select = 5'd0;
  logic [4:0]    loader_select;
  logic [PL-1:0] loader_red, loader_blue, loader_yellow;
  logic [7:0]    loader_total_notes;
  logic          beat_strobe, note_red, note_blue, note_yellow;
  logic [6:0]    beat_index;
  logic [7:0]    total_notes, notes_emitted;
  logic          busy, done;

  int vectors = 0;
  int miscompares = 0;

  song_sequencer #(.BEAT_CYCLES(BC), .PATTERN_LEN(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .song_select(song_select), .loader_select(loader_select),
    .loader_red(loader_red), .loader_blue(loader_blue), .loader_yellow(loader_yellow),
    .loader_total_notes(loader_total_notes), .beat_strobe(beat_strobe),
    .note_red(note_red), .note_blue(note_blue), .note_yellow(note_yellow),
    .beat_index(beat_index), .total_notes(total_notes), .notes_emitted(notes_emitted),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [PL-1:0] pat_red(input logic [4:0] c);
    case (c)
      SONG_BRIAN_FULL_MARKS: return {1'b1, 99'b0};
      SONG_TAKE_ON_ME:       return {25{4'b1000}};
      SONG_VLAD_BIT:         return {100{1'b1}};
      default:               return '0;
    endcase
  endfunction

  function automatic logic [PL-1:0] pat_blue(input logic [4:0] c);
    case (c)
      SONG_TAKE_ON_ME: return {20{5'b01000}};
      SONG_VLAD_BIT:   return {100{1'b1}};
      default:         return '0;
    endcase
  endfunction

  function automatic logic [PL-1:0] pat_yellow(input logic [4:0] c);
    case (c)
      SONG_TAKE_ON_ME:       return {10{10'b0000000001}};
      SONG_VLAD_BIT:         return {100{1'b1}};
      SONG_THROUGH_THE_FIRE: return {100{1'b1}};
      default:               return '0;
    endcase
  endfunction

  function automatic logic [7:0] pat_total(input logic [4:0] c);
    case (c)
      SONG_BRIAN_FULL_MARKS: return 8'd1;
      SONG_TAKE_ON_ME:       return 8'd42;
      SONG_VLAD_BIT:         return 8'd200;
      SONG_THROUGH_THE_FIRE: return 8'd150;
      default:               return 8'd0;
    endcase
  endfunction

  always_comb begin
    loader_red         = pat_red(loader_select);
    loader_blue        = pat_blue(loader_select);
    loader_yellow      = pat_yellow(loader_select);
    loader_total_notes = pat_total(loader_select);
  end

  task automatic do_start(input logic [4:0] code);
    song_select = code;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic play_through(input logic [4:0] code, input int exp_total,
                              input int exp_emitted, input int poke_step);
    logic [PL-1:0] r, b, y;
    logic [2:0]    exp_notes;
    r = pat_red(code);
    b = pat_blue(code);
    y = pat_yellow(code);
    for (int k = 0; k < PL; k++) begin
      for (int j = 0; j < BC - 1; j++) begin
        if (k == poke_step && j == 0) begin
          start = 1'b1;
          song_select = SONG_THROUGH_THE_FIRE;
        end
        if (k == poke_step && j == 1) start = 1'b0;
        @(negedge clk);
        vectors++;
        if (beat_strobe !== 1'b0 || {note_red, note_blue, note_yellow} !== 3'b000) begin
          miscompares++;
          $display("FAIL quiet_cycle song %b step %0d: strobe=%b notes=%b, expected strobe=0 notes=000",
                   code, k, beat_strobe, {note_red, note_blue, note_yellow});
        end
      end
      @(negedge clk);
      exp_notes = {r[PL-1-k], b[PL-1-k], y[PL-1-k]};
      vectors++;
      if (beat_strobe !== 1'b1 || beat_index !== 7'(k)) begin
        miscompares++;
        $display("FAIL beat_strobe song %b step %0d: strobe=%b index=%0d, expected strobe=1 index=%0d",
                 code, k, beat_strobe, beat_index, k);
      end
      vectors++;
      if ({note_red, note_blue, note_yellow} !== exp_notes) begin
        miscompares++;
        $display("FAIL note_bits song %b step %0d: got %b expected %b",
                 code, k, {note_red, note_blue, note_yellow}, exp_notes);
      end
      vectors++;
      if (loader_select !== code || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL playing_status song %b step %0d: loader_select=%b busy=%b done=%b, expected %b 1 0",
                 code, k, loader_select, busy, done, code);
      end
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || beat_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL done_after_last song %b: done=%b busy=%b strobe=%b, expected 1 0 0",
               code, done, busy, beat_strobe);
    end
    vectors++;
    if (notes_emitted !== 8'(exp_emitted) || total_notes !== 8'(exp_total) || beat_index !== 7'd99) begin
      miscompares++;
      $display("FAIL final_counts song %b: emitted=%0d total=%0d index=%0d, expected %0d %0d 99",
               code, notes_emitted, total_notes, beat_index, exp_emitted, exp_total);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || beat_strobe !== 1'b0 || loader_select !== 5'd0 ||
        beat_index !== 7'd0 || total_notes !== 8'd0 || notes_emitted !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b strobe=%b sel=%b idx=%0d total=%0d emitted=%0d, expected all 0",
               busy, done, beat_strobe, loader_select, beat_index, total_notes, notes_emitted);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_single_note();
    do_start(SONG_BRIAN_FULL_MARKS);
    vectors++;
    if (busy !== 1'b1 || loader_select !== SONG_BRIAN_FULL_MARKS) begin
      miscompares++;
      $display("FAIL load_accept: busy=%b sel=%b, expected 1 %b", busy, loader_select, SONG_BRIAN_FULL_MARKS);
    end
    play_through(SONG_BRIAN_FULL_MARKS, 1, 1, -1);
  endtask

  task automatic test_take_on_me();
    do_start(SONG_TAKE_ON_ME);
    play_through(SONG_TAKE_ON_ME, 42, 55, -1);
  endtask

  task automatic test_pause();
    do_start(SONG_BRIAN_FULL_MARKS);
    repeat (BC) @(negedge clk);
    vectors++;
    if (beat_strobe !== 1'b1 || beat_index !== 7'd0) begin
      miscompares++;
      $display("FAIL pause_first_strobe: strobe=%b idx=%0d, expected 1 0", beat_strobe, beat_index);
    end
    @(negedge clk);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (beat_strobe !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL paused_quiet cycle %0d: strobe=%b busy=%b, expected 0 1", i, beat_strobe, busy);
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (beat_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL resume_quiet cycle %0d: strobe=%b, expected 0", i, beat_strobe);
      end
    end
    @(negedge clk);
    vectors++;
    if (beat_strobe !== 1'b1 || beat_index !== 7'd1) begin
      miscompares++;
      $display("FAIL delayed_strobe: strobe=%b idx=%0d, expected 1 1", beat_strobe, beat_index);
    end
    for (int i = 0; i < BC - 1; i++) begin
      @(negedge clk);
      vectors++;
      if (beat_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL pre_collision cycle %0d: strobe=%b, expected 0", i, beat_strobe);
      end
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (beat_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL collision_no_strobe cycle %0d: strobe=%b, expected 0", i, beat_strobe);
      end
    end
    pause = 1'b0;
    @(negedge clk);
    vectors++;
    if (beat_strobe !== 1'b1 || beat_index !== 7'd2) begin
      miscompares++;
      $display("FAIL collision_resume_strobe: strobe=%b idx=%0d, expected 1 2", beat_strobe, beat_index);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort();
    do_start(SONG_VLAD_BIT);
    repeat (51 * BC) @(negedge clk);
    vectors++;
    if (beat_strobe !== 1'b1 || beat_index !== 7'd50 || notes_emitted !== 8'd153) begin
      miscompares++;
      $display("FAIL step50: strobe=%b idx=%0d emitted=%0d, expected 1 50 153",
               beat_strobe, beat_index, notes_emitted);
    end
    abort = 1'b1;
    start = 1'b1;
    song_select = SONG_BRIAN_FULL_MARKS;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || beat_strobe !== 1'b0 || loader_select !== 5'd0 ||
        beat_index !== 7'd0 || total_notes !== 8'd0 || notes_emitted !== 8'd0 ||
        {note_red, note_blue, note_yellow} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_clears: busy=%b done=%b strobe=%b sel=%b idx=%0d total=%0d emitted=%0d, expected all 0",
               busy, done, beat_strobe, loader_select, beat_index, total_notes, notes_emitted);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || loader_select !== 5'd0) begin
      miscompares++;
      $display("FAIL abort_start_ignored: busy=%b sel=%b, expected 0 00000", busy, loader_select);
    end
    do_start(SONG_VLAD_BIT);
    play_through(SONG_VLAD_BIT, 200, 255, -1);
  endtask

  task automatic test_done_restart();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_precondition: done=%b, expected 1", done);
    end
    do_start(SONG_NONE);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || notes_emitted !== 8'd0 || beat_index !== 7'd0 ||
        loader_select !== SONG_NONE) begin
      miscompares++;
      $display("FAIL restart_from_done: done=%b busy=%b emitted=%0d idx=%0d sel=%b, expected 0 1 0 0 00000",
               done, busy, notes_emitted, beat_index, loader_select);
    end
    play_through(SONG_NONE, 0, 0, 10);
  endtask

  task automatic test_async_reset();
    do_start(SONG_TAKE_ON_ME);
    repeat (20) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || notes_emitted === 8'd0) begin
      miscompares++;
      $display("FAIL pre_reset_play: busy=%b emitted=%0d, expected busy 1 and emitted nonzero",
               busy, notes_emitted);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || beat_strobe !== 1'b0 || loader_select !== 5'd0 ||
        beat_index !== 7'd0 || total_notes !== 8'd0 || notes_emitted !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b strobe=%b sel=%b idx=%0d total=%0d emitted=%0d, expected all 0",
               busy, done, beat_strobe, loader_select, beat_index, total_notes, notes_emitted);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || beat_strobe !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_release cycle %0d: busy=%b done=%b strobe=%b, expected 0 0 0",
                 i, busy, done, beat_strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_take_on_me();
    test_pause();
    test_abort();
    test_done_restart();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
